// File: rtl/toy_fetch_buffer_pkg.sv
// Shared fetch-queue types.
// Entry payload and bypass bundle.
package toy_pack;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  typedef struct packed {
    logic       taken;
    logic [3:0] idx;
  } fe_bypass_pkg;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    fe_bypass_pkg          fe_bypass;
  } fetch_queue_pkg;

endpackage

// File: rtl/toy_fetch_buffer.sv
// Per-lane fetch FIFO: multi-lane packed write,
// single FWFT read port.
module toy_fetch_buffer
  import toy_pack::*;
#(
  parameter int DEPTH  = 16,
  parameter int MUX_IN = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cancel_en,
  output logic                         req_rdy,
  input  logic                         req_vld,
  input  fetch_queue_pkg [MUX_IN-1:0]  v_req_pld,
  input  logic [MUX_IN-1:0]            v_req_en,
  output logic                         v_ack_vld,
  input  logic                         v_ack_rdy,
  output logic [ADDR_WIDTH-1:0]        v_ack_pc,
  output logic [INST_WIDTH-1:0]        v_ack_pld,
  output fe_bypass_pkg                 v_fe_pld
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  count;
  logic [PW-1:0]  wr_cnt;
  logic [AW-1:0]  slot [MUX_IN];
  logic           wr_fire;
  logic           pop;
  logic           flush;
  fetch_queue_pkg head;
  fetch_queue_pkg mem [DEPTH];

  function automatic logic [PW-1:0] prefix(
    input logic [MUX_IN-1:0] en,
    input int                upto
  );
    logic [PW-1:0] acc;
    acc = '0;
    for (int k = 0; k < MUX_IN; k++) begin
      if (k < upto) acc = acc + PW'(en[k]);
    end
    return acc;
  endfunction

  assign count     = wr_ptr - rd_ptr;
  assign req_rdy   = (count <= PW'(DEPTH - MUX_IN));
  assign v_ack_vld = (count != '0);
  assign flush     = rst_n | cancel_en;
  assign wr_fire   = req_vld & req_rdy & ~flush;
  assign pop       = v_ack_vld & v_ack_rdy & ~flush;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign v_ack_pc  = head.pc;
  assign v_ack_pld = head.inst;
  assign v_fe_pld  = head.fe_bypass;

  // Pack enabled lanes: slot of lane j is wr_ptr plus enables below j.
  always_comb begin
    wr_cnt = prefix(v_req_en, MUX_IN);
    for (int j = 0; j < MUX_IN; j++) begin
      slot[j] = wr_ptr[AW-1:0]
              + AW'(prefix(v_req_en, j));
    end
  end

  // Pointer update; flush wins over write and pop.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + wr_cnt;
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents survive flush.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int j = 0; j < MUX_IN; j++) begin
        if (v_req_en[j]) mem[slot[j]] <= v_req_pld[j];
      end
    end
  end

endmodule

// File: tb/tb_toy_fetch_buffer.sv
// Directed bench for toy_fetch_buffer with
// a queue scoreboard of expected head entries.
module tb_toy_fetch_buffer;
  import toy_pack::*;

  localparam int DEPTH  = 16;
  localparam int MUX_IN = 2;

  logic                        clk;
  logic                        rst_n;
  logic                        cancel_en;
  logic                        req_rdy;
  logic                        req_vld;
  fetch_queue_pkg [MUX_IN-1:0] v_req_pld;
  logic [MUX_IN-1:0]           v_req_en;
  logic                        v_ack_vld;
  logic                        v_ack_rdy;
  logic [ADDR_WIDTH-1:0]       v_ack_pc;
  logic [INST_WIDTH-1:0]       v_ack_pld;
  fe_bypass_pkg                v_fe_pld;

  fetch_queue_pkg q[$];
  int total = 0;
  int bad   = 0;

  toy_fetch_buffer #(
    .DEPTH (DEPTH),
    .MUX_IN(MUX_IN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cancel_en(cancel_en),
    .req_rdy  (req_rdy),
    .req_vld  (req_vld),
    .v_req_pld(v_req_pld),
    .v_req_en (v_req_en),
    .v_ack_vld(v_ack_vld),
    .v_ack_rdy(v_ack_rdy),
    .v_ack_pc (v_ack_pc),
    .v_ack_pld(v_ack_pld),
    .v_fe_pld (v_fe_pld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fetch_queue_pkg mk(input logic [31:0] pc);
    fetch_queue_pkg e;
    e.pc              = pc;
    e.inst            = pc ^ 32'hA5A5_0000;
    e.fe_bypass.taken = pc[2];
    e.fe_bypass.idx   = pc[7:4];
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check against model at negedge, update model.
  task automatic cyc(input logic        vld,
                     input logic [1:0]  en,
                     input logic [31:0] p0,
                     input logic [31:0] p1,
                     input logic        ardy,
                     input logic        cx,
                     input logic        rs);
    logic acc;
    req_vld      = vld;
    v_req_en     = en;
    v_req_pld[0] = mk(p0);
    v_req_pld[1] = mk(p1);
    v_ack_rdy    = ardy;
    cancel_en    = cx;
    rst_n        = rs;
    @(negedge clk);
    chk("ack_vld", 64'(v_ack_vld), 64'(q.size() != 0));
    chk("req_rdy", 64'(req_rdy), 64'(q.size() <= DEPTH - MUX_IN));
    if (q.size() != 0) begin
      chk("head_pc", 64'(v_ack_pc), 64'(q[0].pc));
      chk("head_inst", 64'(v_ack_pld), 64'(q[0].inst));
      chk("head_fe", 64'(v_fe_pld), 64'(q[0].fe_bypass));
    end
    if (rs || cx) begin
      q.delete();
    end else begin
      acc = vld && (q.size() <= DEPTH - MUX_IN);
      if (ardy && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        if (en[0]) q.push_back(mk(p0));
        if (en[1]) q.push_back(mk(p1));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ardy);
    cyc(1'b0, 2'b00, 32'hBAD0_0000, 32'hBAD0_0004, ardy, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] nxt;
    logic [1:0]  en;
    logic [31:0] p0;
    logic [31:0] p1;
    int          n;
    rst_n     = 1'b1;
    cancel_en = 1'b0;
    req_vld   = 1'b0;
    v_req_en  = '0;
    v_req_pld = '0;
    v_ack_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk("rst_vld", 64'(v_ack_vld), 64'd0);
    chk("rst_rdy", 64'(req_rdy), 64'd1);
    repeat (3) idle(1'b0);

    cyc(1'b1, 2'b11, 32'h100, 32'h104, 1'b1, 1'b0, 1'b0);
    chk("two_first", 64'(v_ack_pc), 64'h100);
    idle(1'b1);
    chk("two_second", 64'(v_ack_pc), 64'h104);
    idle(1'b1);
    chk("two_empty", 64'(v_ack_vld), 64'd0);

    cyc(1'b1, 2'b10, 32'h200, 32'h204, 1'b0, 1'b0, 1'b0);
    chk("lane1_pc", 64'(v_ack_pc), 64'h204);
    cyc(1'b1, 2'b00, 32'h300, 32'h304, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    chk("lane1_one", 64'(v_ack_vld), 64'd0);

    for (int i = 0; i < 7; i++)
      cyc(1'b1, 2'b11, 32'h1000 + 32'(8 * i),
          32'h1004 + 32'(8 * i), 1'b0, 1'b0, 1'b0);
    chk("fill14_rdy", 64'(req_rdy), 64'd1);
    cyc(1'b1, 2'b01, 32'h1038, 32'hBAD0_0038, 1'b0, 1'b0, 1'b0);
    chk("fill15_rdy", 64'(req_rdy), 64'd0);
    cyc(1'b1, 2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    chk("pop14_rdy", 64'(req_rdy), 64'd1);
    cyc(1'b1, 2'b11, 32'h1040, 32'h1044, 1'b1, 1'b0, 1'b0);
    chk("wrpop_rdy", 64'(req_rdy), 64'd0);
    chk("wrpop_head", 64'(v_ack_pc), 64'h1008);

    nxt = 32'h2000;
    n   = 0;
    for (int c = 0; c < 600 && (n < 40 || q.size() != 0); c++) begin
      en = (n < 40) ? 2'($urandom_range(0, 3)) : 2'b00;
      p0 = 32'hBAD1_0000;
      p1 = 32'hBAD1_0004;
      if (en == 2'b11) begin
        p0 = nxt;
        p1 = nxt + 32'd4;
      end else if (en == 2'b01) begin
        p0 = nxt;
      end else if (en == 2'b10) begin
        p1 = nxt;
      end
      if (n < 40 && q.size() <= DEPTH - MUX_IN) begin
        n   = n + int'(en[0]) + int'(en[1]);
        nxt = nxt + 32'(4 * (int'(en[0]) + int'(en[1])));
      end
      cyc(n < 40 || en != 2'b00, en, p0, p1,
          $urandom_range(0, 3) != 0, 1'b0, 1'b0);
    end
    chk("stream_drained", 64'(v_ack_vld), 64'd0);

    cyc(1'b1, 2'b11, 32'h3000, 32'h3004, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 32'h3008, 32'h300C, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 32'h3010, 32'hBAD2_0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 32'h3100, 32'h3104, 1'b1, 1'b1, 1'b0);
    chk("cancel_vld", 64'(v_ack_vld), 64'd0);
    chk("cancel_rdy", 64'(req_rdy), 64'd1);
    cyc(1'b1, 2'b01, 32'h900, 32'hBAD2_0004, 1'b0, 1'b0, 1'b0);
    chk("cancel_new", 64'(v_ack_pc), 64'h900);
    idle(1'b1);

    cyc(1'b1, 2'b11, 32'h4000, 32'h4004, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 32'h4008, 32'h400C, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 32'h4100, 32'h4104, 1'b1, 1'b0, 1'b1);
    chk("reset_vld", 64'(v_ack_vld), 64'd0);
    chk("reset_rdy", 64'(req_rdy), 64'd1);
    cyc(1'b1, 2'b10, 32'hBAD3_0000, 32'hA00, 1'b0, 1'b0, 1'b0);
    chk("reset_new", 64'(v_ack_pc), 64'hA00);
    idle(1'b1);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
